vie_sram_arbiter: RTL

//  Shares one synchronous single-port SRAM between two requesters: port I (IF-stage fetch) and port D (EXE-stage load/store).

---
 rtl/vie_sram_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/vie_sram_arbiter.sv
// Two-port arbiter in front of one synchronous single-port SRAM: D-stage priority with an
// I-stage starvation guard, read-response routing and a one-deep hold buffer per port.
module vie_sram_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clock,
  input  logic                reset,
  // Port I (fetch)
  input  logic                i_req,
  input  logic [DATA_W/8-1:0] i_wen,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic                i_gnt,
  output logic                i_rvalid,
  input  logic                i_rready,
  output logic [DATA_W-1:0]   i_rdata,
  // Port D (load/store)
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_wen,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  input  logic                d_rready,
  output logic [DATA_W-1:0]   d_rdata,
  // SRAM
  output logic                m_en,
  output logic [DATA_W/8-1:0] m_wen,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int unsigned BE_W      = DATA_W / 8;
  localparam logic [3:0]  StarveMax = 4'(STARVE_MAX);

  typedef enum logic {PortI = 1'b0, PortD = 1'b1} port_e;

  // Pending-read tracker, hold buffers and starvation counter
  logic              r_rd_v;
  port_e             r_rd_port;
  logic              r_hold_v_i;
  logic              r_hold_v_d;
  logic [DATA_W-1:0] r_hold_data_i;
  logic [DATA_W-1:0] r_hold_data_d;
  logic [3:0]        r_starve_cnt;

  logic              w_rd_v_nxt;
  port_e             w_rd_port_nxt;
  logic              w_hold_v_i_nxt;
  logic              w_hold_v_d_nxt;
  logic [DATA_W-1:0] w_hold_data_i_nxt;
  logic [DATA_W-1:0] w_hold_data_d_nxt;
  logic [3:0]        w_starve_cnt_nxt;

  logic w_byp_i;
  logic w_byp_d;
  logic w_elig_i;
  logic w_elig_d;
  logic w_starve_hit;
  logic w_gnt_i;
  logic w_gnt_d;
  logic w_gnt_read;

  assign w_byp_i = r_rd_v && (r_rd_port == PortI);
  assign w_byp_d = r_rd_v && (r_rd_port == PortD);

  // A port whose previous response will not be consumed this cycle gets no new grant
  assign w_elig_i = i_req && !r_hold_v_i && !(w_byp_i && !i_rready);
  assign w_elig_d = d_req && !r_hold_v_d && !(w_byp_d && !d_rready);

  assign w_starve_hit = (r_starve_cnt == StarveMax);

  assign w_gnt_i = !reset && w_elig_i && (!w_elig_d || w_starve_hit);
  assign w_gnt_d = !reset && w_elig_d && !w_gnt_i;

  assign i_gnt = w_gnt_i;
  assign d_gnt = w_gnt_d;

  // SRAM drive: granted port passes straight through
  always_comb begin
    m_en       = 1'b0;
    m_wen      = '0;
    m_addr     = '0;
    m_wdata    = '0;
    w_gnt_read = 1'b0;
    if (w_gnt_i) begin
      m_en       = 1'b1;
      m_wen      = i_wen;
      m_addr     = i_addr;
      m_wdata    = i_wdata;
      w_gnt_read = (i_wen == '0);
    end else if (w_gnt_d) begin
      m_en       = 1'b1;
      m_wen      = d_wen;
      m_addr     = d_addr;
      m_wdata    = d_wdata;
      w_gnt_read = (d_wen == '0);
    end
  end

  // Responses: hold buffer first, else bypass of the SRAM read data
  always_comb begin
    i_rvalid = 1'b0;
    i_rdata  = '0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    if (!reset) begin
      if (r_hold_v_i) begin
        i_rvalid = 1'b1;
        i_rdata  = r_hold_data_i;
      end else if (w_byp_i) begin
        i_rvalid = 1'b1;
        i_rdata  = m_rdata;
      end
      if (r_hold_v_d) begin
        d_rvalid = 1'b1;
        d_rdata  = r_hold_data_d;
      end else if (w_byp_d) begin
        d_rvalid = 1'b1;
        d_rdata  = m_rdata;
      end
    end
  end

  always_comb begin
    w_rd_v_nxt        = w_gnt_read;
    w_rd_port_nxt     = w_gnt_d ? PortD : PortI;
    w_hold_v_i_nxt    = r_hold_v_i;
    w_hold_v_d_nxt    = r_hold_v_d;
    w_hold_data_i_nxt = r_hold_data_i;
    w_hold_data_d_nxt = r_hold_data_d;
    w_starve_cnt_nxt  = r_starve_cnt;

    if (r_hold_v_i) begin
      if (i_rready) w_hold_v_i_nxt = 1'b0;
    end else if (w_byp_i && !i_rready) begin
      w_hold_v_i_nxt    = 1'b1;
      w_hold_data_i_nxt = m_rdata;
    end

    if (r_hold_v_d) begin
      if (d_rready) w_hold_v_d_nxt = 1'b0;
    end else if (w_byp_d && !d_rready) begin
      w_hold_v_d_nxt    = 1'b1;
      w_hold_data_d_nxt = m_rdata;
    end

    if (!i_req || w_gnt_i) begin
      w_starve_cnt_nxt = '0;
    end else if (w_elig_i && (r_starve_cnt != 4'hF)) begin
      w_starve_cnt_nxt = r_starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_v        <= 1'b0;
      r_rd_port     <= PortI;
      r_hold_v_i    <= 1'b0;
      r_hold_v_d    <= 1'b0;
      r_hold_data_i <= '0;
      r_hold_data_d <= '0;
      r_starve_cnt  <= '0;
    end else begin
      r_rd_v        <= w_rd_v_nxt;
      r_rd_port     <= w_rd_port_nxt;
      r_hold_v_i    <= w_hold_v_i_nxt;
      r_hold_v_d    <= w_hold_v_d_nxt;
      r_hold_data_i <= w_hold_data_i_nxt;
      r_hold_data_d <= w_hold_data_d_nxt;
      r_starve_cnt  <= w_starve_cnt_nxt;
    end
  end

  logic [BE_W-1:0] w_unused_be;
  assign w_unused_be = '0;

endmodule
